// File: rtl/calc_launch.sv
// calc_launch: batch launcher driving start pulses and collecting done.
// Define CALC_PROTO_CHECK_EN to enable the en_in protocol check.
module calc_launch #(
  parameter int START_W = 2,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [CNT_W-1:0] n_jobs,
  output logic             start,
  input  logic             done_in,
  input  logic             en_in,
  output logic             busy,
  output logic [CNT_W-1:0] jobs_done,
  output logic             all_done,
  output logic             err,
  output logic [1:0]       err_code
);

  typedef enum logic [1:0] {
    IDLE, ASSERT, WAIT, GAP
  } state_t;

  localparam logic [3:0] SW = 4'(START_W);
  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] jobs_q, jobs_d;
  logic [CNT_W-1:0] jobs_inc;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [7:0]       tcnt_q, tcnt_d;
  logic             all_q, all_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic             en_q, en_d;
  logic             proto_bad;

  always_comb begin
    proto_bad = 1'b0;
`ifdef CALC_PROTO_CHECK_EN
    unique case (state_q)
      WAIT:        proto_bad = (en_in & (done_in | en_q))
                             | (done_in & ~en_q);
      ASSERT, GAP: proto_bad = en_in;
      default:     proto_bad = 1'b0;
    endcase
`endif
  end

`ifndef CALC_PROTO_CHECK_EN
  logic unused_en;
  assign unused_en = en_in;
`endif

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    jobs_d   = jobs_q;
    wcnt_d   = wcnt_q;
    tcnt_d   = tcnt_q;
    all_d    = 1'b0;
    err_d    = err_q;
    code_d   = code_q;
    en_d     = en_q;
    jobs_inc = (&jobs_q) ? jobs_q : jobs_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          jobs_d = '0;
          err_d  = 1'b0;
          code_d = 2'b00;
          if (n_jobs == '0) begin
            all_d = 1'b1;
          end else begin
            n_d     = n_jobs;
            wcnt_d  = 4'd1;
            en_d    = 1'b0;
            state_d = ASSERT;
          end
        end
      end
      ASSERT: begin
        if (done_in) begin
          err_d   = 1'b1;
          code_d  = 2'b11;
          state_d = IDLE;
        end else if (proto_bad) begin
          err_d   = 1'b1;
          code_d  = 2'b10;
          state_d = IDLE;
        end else if (wcnt_q == SW) begin
          tcnt_d  = 8'd1;
          state_d = WAIT;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      WAIT: begin
        if (proto_bad) begin
          err_d   = 1'b1;
          code_d  = 2'b10;
          state_d = IDLE;
        end else if (done_in) begin
          jobs_d = jobs_inc;
          if (jobs_inc == n_q) begin
            all_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = GAP;
          end
        end else begin
          if (en_in) en_d = 1'b1;
          if (tcnt_q == TO) begin
            err_d   = 1'b1;
            code_d  = 2'b01;
            state_d = IDLE;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
      end
      GAP: begin
        if (done_in) begin
          err_d   = 1'b1;
          code_d  = 2'b11;
          state_d = IDLE;
        end else if (proto_bad) begin
          err_d   = 1'b1;
          code_d  = 2'b10;
          state_d = IDLE;
        end else begin
          wcnt_d  = 4'd1;
          en_d    = 1'b0;
          state_d = ASSERT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      jobs_q  <= '0;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      all_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      jobs_q  <= jobs_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      all_q   <= all_d;
      err_q   <= err_d;
      code_q  <= code_d;
      en_q    <= en_d;
    end
  end

  assign start     = (state_q == ASSERT);
  assign busy      = (state_q != IDLE);
  assign jobs_done = jobs_q;
  assign all_done  = all_q;
  assign err       = err_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_calc_launch.sv
// tb_calc_launch: directed batch vectors with a simple controller model.
// Expectations for the en-without-done row depend on CALC_PROTO_CHECK_EN.
module tb_calc_launch;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic [7:0] n_jobs = '0;
  logic       start;
  logic       done_in = 1'b0;
  logic       en_in = 1'b0;
  logic       busy;
  logic [7:0] jobs_done;
  logic       all_done;
  logic       err;
  logic [1:0] err_code;

  calc_launch #(.START_W(2), .TIMEOUT(15), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .n_jobs(n_jobs),
    .start(start), .done_in(done_in), .en_in(en_in),
    .busy(busy), .jobs_done(jobs_done), .all_done(all_done),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n; int resp; int no_en; int poke; int spur;
    int e_jobs; int e_err; int e_code; int e_all;
    int e_starts; int e_busy; int e_errw;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  int r_all, r_starts, r_busy, r_errw, r_per_bad, r_ovl, r_fin;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_batch(input vec_t v);
    int cyc, w, job, rise_prev;
    bit prev_start;
    r_all = 0; r_starts = 0; r_busy = 0; r_errw = 0;
    r_per_bad = 0; r_ovl = 0; r_fin = 0;
    cyc = 0; w = 0; job = 0; rise_prev = -1; prev_start = 1'b0;
    @(negedge clk);
    req = 1'b1;
    n_jobs = 8'(v.n);
    while (r_fin == 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      req = 1'b0; en_in = 1'b0; done_in = 1'b0;
      if (start && !prev_start) begin
        if (rise_prev >= 0 && cyc - rise_prev != 6) r_per_bad = 1;
        rise_prev = cyc;
        r_starts++;
        if (v.spur != 0 && r_starts == 1) done_in = 1'b1;
      end
      if (!start && prev_start) w = 1;
      else if (w > 0) w++;
      if (busy) r_busy = 1;
      if (all_done) r_all++;
      if (all_done && (busy || err)) r_ovl = 1;
      if (err && r_errw == 0) r_errw = w;
      if (w > 0 && job < v.resp) begin
        if (w == 1 && v.no_en == 0) en_in = 1'b1;
        if (w == 3) begin
          done_in = 1'b1;
          job++;
          w = 0;
        end
      end
      if (v.poke != 0 && job == 0 && w == 2) begin
        req = 1'b1;
        n_jobs = 8'd1;
      end
      prev_start = start;
      if (!busy && (all_done || err)) r_fin = 1;
    end
    req = 1'b0; en_in = 1'b0; done_in = 1'b0;
    chk("batch_ends", r_fin, 1);
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d_", idx);
    chk({p, "jobs_done"}, jobs_done, v.e_jobs);
    chk({p, "err"}, err, v.e_err);
    chk({p, "err_code"}, err_code, v.e_code);
    chk({p, "all_done_cnt"}, r_all, v.e_all);
    chk({p, "starts"}, r_starts, v.e_starts);
    chk({p, "busy_seen"}, r_busy, v.e_busy);
    chk({p, "overlap"}, r_ovl, 0);
    chk({p, "period"}, r_per_bad, 0);
    if (v.e_code == 1) chk({p, "timeout_cyc"}, r_errw, v.e_errw);
  endtask

  vec_t tv[10];
  vec_t v;

  initial begin
    //         n resp noen poke spur jobs err code all st busy errw
    tv[0] = '{3, 3, 0, 0, 0, 3, 0, 0, 1, 3, 1, 0};
    tv[1] = '{1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0};
    tv[2] = '{4, 2, 0, 0, 0, 2, 1, 1, 0, 3, 1, 16};
    tv[3] = '{5, 5, 0, 0, 0, 5, 0, 0, 1, 5, 1, 0};
    tv[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    tv[5] = '{2, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 16};
    tv[6] = '{3, 0, 0, 0, 1, 0, 1, 3, 0, 1, 1, 0};
    tv[7] = '{1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0};
    tv[8] = '{3, 3, 0, 1, 0, 3, 0, 0, 1, 3, 1, 0};
`ifdef CALC_PROTO_CHECK_EN
    tv[9] = '{1, 1, 1, 0, 0, 0, 1, 2, 0, 1, 1, 0};
`else
    tv[9] = '{1, 1, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0};
`endif

    #1;
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_jobs", jobs_done, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_batch(tv[i]);
      check_vec(i, tv[i]);
    end

    // asynchronous reset while start is high
    @(negedge clk);
    req = 1'b1;
    n_jobs = 8'd2;
    @(negedge clk);
    req = 1'b0;
    chk("pre_rst_start", start, 1);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_start", start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_jobs", jobs_done, 0);
    chk("arst_err", err, 0);
    @(negedge clk);
    rst = 1'b1;
    v = '{2, 2, 0, 0, 0, 2, 0, 0, 1, 2, 1, 0};
    run_batch(v);
    check_vec(99, v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/calc_launch.md
# calc_launch

Host-side launcher for the calculation controller's start/done/en handshake. It accepts a batch request for N jobs and drives `start` pulses of fixed width. After each pulse it waits for `done`, counts completions, and flags a timeout. It sits between the host/bus logic and the controller instances: it issues `start` and consumes `done` and `en`.

## Interface
- `START_W`, default 2: cycles `start` is held high per job (1..15).
- `TIMEOUT`, default 15: maximum WAIT cycles allowed for `done_in` (1..255).
- `CNT_W`, default 8: width of the job count and completion counter.
- `clk`, input, 1: clock; all state changes on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `req`, input, 1: one-cycle batch request; sampled only in IDLE.
- `n_jobs`, input, CNT_W: job count, captured with `req`.
- `start`, output, 1: start to the controller.
- `done_in`, input, 1: done from the controller.
- `en_in`, input, 1: en from the controller (protocol check only).
- `busy`, output, 1: high from request acceptance until return to IDLE.
- `jobs_done`, output, CNT_W: completed jobs in the current or last batch.
- `all_done`, output, 1: one-cycle pulse when the batch completes normally.
- `err`, output, 1: sticky error flag.
- `err_code`, output, 2: 00 none, 01 timeout, 10 en protocol, 11 spurious done.

## Operation
- **Reset values:** all outputs 0; state IDLE; internal counters 0. Assertion mid-operation drops `start` immediately (asynchronous) and abandons the batch.
- **States:** IDLE, ASSERT, WAIT, GAP.
- **IDLE, `req`=1, `n_jobs`≠0:** capture `n_jobs`; clear `jobs_done`, `err`, `err_code`; set `busy`; go to ASSERT.
- **IDLE, `req`=1, `n_jobs`=0:** clear counters and error; pulse `all_done` next cycle; `busy` stays 0; no `start`.
- **`req` while `busy`:** ignored; `n_jobs` is not recaptured.
- **ASSERT:** `start`=1 for exactly START_W cycles, counted by a width counter, then go to WAIT.
- **WAIT:** `start`=0; the timeout counter increments each cycle.
  - `done_in`=1: increment `jobs_done`.
    - If the new value equals the captured `n_jobs`: go to IDLE, pulse `all_done`, drop `busy`.
    - Otherwise: go to GAP.
  - Timeout counter reaches TIMEOUT with no `done_in`: set `err`, `err_code`=01, go to IDLE, drop `busy`. The remaining jobs are abandoned and `jobs_done` holds its value.
- **GAP:** exactly one cycle with `start`=0, letting the controller return to idle; then ASSERT.
- **`done_in`=1 in ASSERT or GAP:** spurious. Set `err`, `err_code`=11, abort to IDLE.
- **Error precedence (same cycle):** 11 > 10 > 01. The first error is retained; the code is not overwritten until the next accepted `req`.
- **`jobs_done`:** saturates at all-ones (cannot exceed `n_jobs` anyway); no wrap.

## Timing
- `req` sampled at edge T → `busy`=1 and `start`=1 from T+1, held through T+START_W.
- `start` falls at edge T+START_W+1; WAIT begins that cycle, with the timeout counter at 1 in that first cycle.
- `done_in` sampled at edge D in WAIT:
  - `jobs_done` updates after D.
  - For the last job, `all_done`=1 and `busy`=0 during cycle D+1.
  - Otherwise, GAP during cycle D+1 and `start` rises again at D+2.
- Per-job period with done after k WAIT cycles: START_W + k + 1 cycles.
- Timeout: if `done_in` is absent through the TIMEOUT-th WAIT cycle, `err` rises in the next cycle.
- `all_done` and `err` never assert in the same cycle.

## Configuration
- **`CALC_PROTO_CHECK_EN` defined:** in WAIT, `en_in` must be high for exactly one cycle strictly before `done_in`. Tracked with a per-job flag, cleared on entering ASSERT. Violations set `err_code`=10 and abort to IDLE:
  - `done_in` with no prior `en_in`;
  - a second `en_in`;
  - `en_in` coincident with `done_in`;
  - `en_in` outside WAIT.
- **Not defined:** `en_in` is ignored and code 10 never occurs; timeout and spurious-done checks remain.

## Test plan
- **Normal batch:** START_W=2, `n_jobs`=3, model answers `en` 1 cycle and `done` 2 cycles after `start` falls → 3 start pulses 2 cycles wide, 6-cycle period; `jobs_done`=3; one `all_done` pulse; `busy` low after; `err`=0.
- **Zero jobs:** `req` with `n_jobs`=0 → no `start`; `all_done` pulse next cycle; `jobs_done`=0; `busy` never high.
- **Timeout:** TIMEOUT=15, `n_jobs`=4, model stops responding after job 2 → `err`=1, `err_code`=01 16 cycles after the third `start` falls; `jobs_done`=2; no `all_done`.
- **Spurious done and ignored request:** `done_in` pulsed during ASSERT of job 1 → `err_code`=11, abort; a `req` issued while `busy` is ignored; the next `req` in IDLE clears `err`.
- **Protocol check (macro on):** `done` without `en` → `err_code`=10. Macro off, same stimulus → the job counts normally.
- **Reset mid-operation:** `rst` low during ASSERT → `start`, `busy`, `jobs_done`, and `err` go to 0 asynchronously. After release, a new `req` runs normally.
